// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: FSM states, opcodes,
// ALU control codes, immediate-format codes and datapath mux selects.
package rv_ctrl_pkg;

  // FETCH is encoding 0, so state_o reads FETCH both during and after reset.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  // Opcodes of the supported instructions
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALU operation class handed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate extender formats
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // Memory address select
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  // Result mux select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALU A operand select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Per-state control word before reset gating and ALU decoding
  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  // Immediate format depends only on the opcode, whatever the state
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: turns the FSM's operation class plus the funct
// fields into the ALU control code.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  // sub only for R-type with funct7b5 set; I-type addi never subtracts
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32 core (lw, sw, R/I ALU ops, beq).
// Outputs are decoded from the current state and the instruction fields held
// in the instruction register; FETCH/MEMWR enables follow mem_ready and the
// BEQ PC enable follows the ALU zero flag. All outputs are forced low while
// rst_n is low so no write enable survives a reset assertion.
// WAIT_LIMIT must be at least 1 and below 2**CNT_W.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LIMIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             waiting;
  logic             timeout;
  ctrl_t            ctrl;
  logic [2:0]       alu_ctl;

  // A memory-wait cycle, and the one that exhausts the wait budget
  always_comb begin
    waiting = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
              && !mem_ready;
    timeout = waiting && (wait_q == WAIT_LAST);
  end

  // Next-state logic; a completed handshake always beats the wait timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = op[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
    if (timeout) state_d = S_TRAP;
  end

  // Wait counter restarts on every state change and counts stalled cycles
  always_comb begin
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
  end

  // State and wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Per-state control word; enables default low, selects default 00
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.adrsrc    = ADR_PC;
        ctrl.alusrca   = SRCA_PC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.resultsrc = RES_ALU;
        ctrl.irwrite   = mem_ready;
        ctrl.pcwrite   = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrca = SRCA_OLDPC;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.adrsrc    = ADR_ALUOUT;
        ctrl.resultsrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.resultsrc  = RES_DATA;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.adrsrc     = ADR_ALUOUT;
        ctrl.memwrite   = mem_ready;
        ctrl.instr_done = mem_ready;
      end
      S_EXECR: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.alusrcb = SRCB_RS2;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.resultsrc  = RES_ALUOUT;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alusrca    = SRCA_RS1;
        ctrl.alusrcb    = SRCB_RS2;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.resultsrc  = RES_ALUOUT;
        ctrl.pcwrite    = zero;
        ctrl.instr_done = 1'b1;
      end
      S_TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (ctrl.aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (alu_ctl)
  );

  // Output stage: everything is held at zero while reset is asserted
  always_comb begin
    pcwrite    = rst_n & ctrl.pcwrite;
    adrsrc     = rst_n & ctrl.adrsrc;
    memwrite   = rst_n & ctrl.memwrite;
    irwrite    = rst_n & ctrl.irwrite;
    regwrite   = rst_n & ctrl.regwrite;
    resultsrc  = rst_n ? ctrl.resultsrc : 2'b00;
    alusrca    = rst_n ? ctrl.alusrca : 2'b00;
    alusrcb    = rst_n ? ctrl.alusrcb : 2'b00;
    immsrc     = rst_n ? imm_sel(op) : 2'b00;
    alucontrol = rst_n ? alu_ctl : 3'b000;
    instr_done = rst_n & ctrl.instr_done;
    illegal    = rst_n & ctrl.illegal;
    state_o    = rst_n ? state_q : S_FETCH;
  end

endmodule
